// File: rtl/serial_alu.sv
// Bit-serial ALU sequencer: processes one bit per cycle, LSB first, with the
// carry held in a register and result bits collected in a right-shifting register.
module serial_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       control,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic             carryout,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);

   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_SUB = 3'd3;
   localparam logic [2:0] OP_AND = 3'd4;
   localparam logic [2:0] OP_OR  = 3'd5;
   localparam logic [2:0] OP_NOR = 3'd6;
   localparam logic [2:0] OP_XOR = 3'd7;

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_next;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic [WIDTH-1:0] a_sh, b_sh, shift_reg;
   logic [2:0]       op;

   logic             last_bit, arith, b_eff, res_bit, carry_next;
   logic [WIDTH-1:0] shift_next;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   assign last_bit = (cnt == LAST);

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: if (start) state_next = RUN;
         RUN: begin
            busy = 1'b1;
            if (last_bit) state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // One-bit slice: subtraction is addition of ~B with the carry preset to 1.
   always_comb begin
      arith      = (op == OP_ADD) || (op == OP_SUB);
      b_eff      = (op == OP_SUB) ? ~b_sh[0] : b_sh[0];
      res_bit    = 1'b0;
      carry_next = carry;
      case (op)
         OP_ADD, OP_SUB: begin
            res_bit    = a_sh[0] ^ b_eff ^ carry;
            carry_next = (a_sh[0] & b_eff) | (a_sh[0] & carry) | (b_eff & carry);
         end
         OP_AND:  res_bit = a_sh[0] & b_sh[0];
         OP_OR:   res_bit = a_sh[0] | b_sh[0];
         OP_NOR:  res_bit = ~(a_sh[0] | b_sh[0]);
         OP_XOR:  res_bit = a_sh[0] ^ b_sh[0];
         default: res_bit = 1'b0;
      endcase
      shift_next = {res_bit, shift_reg[WIDTH-1:1]};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt       <= '0;
         carry     <= 1'b0;
         a_sh      <= '0;
         b_sh      <= '0;
         op        <= 3'd0;
         shift_reg <= '0;
         out       <= '0;
         carryout  <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
         negative  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh  <= A;
                  b_sh  <= B;
                  op    <= control;
                  cnt   <= '0;
                  carry <= (control == OP_SUB);
               end
            end
            RUN: begin
               a_sh      <= a_sh >> 1;
               b_sh      <= b_sh >> 1;
               shift_reg <= shift_next;
               carry     <= carry_next;
               cnt       <= cnt + 1'b1;
               // Flags commit only on the completing edge; held throughout the run.
               if (last_bit) begin
                  out      <= shift_next;
                  carryout <= arith & carry_next;
                  overflow <= arith & (carry ^ carry_next);
                  zero     <= (shift_next == '0);
                  negative <= shift_next[WIDTH-1];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/serial_alu.md
Name: serial_alu

Overview:
- Bit-serial multi-bit ALU sequencer: accepts a WIDTH-bit operation request and drives one internal 1-bit ALU slice per cycle, LSB first.
- Carry is kept in a register between bits; result bits are collected in a shift register.
- Uses the lab ALU control encoding: 2=ADD, 3=SUB, 4=AND, 5=OR, 6=NOR, 7=XOR.
- Sits beside the datapath as a small-area alternative to the ripple-carry ALU, and serves as the issuing/collecting end for the 1-bit slice.

Parameters:
WIDTH, 32, operand/result width in bits (>=2)

Ports:
clock  input  1  single clock, rising-edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE
A  input  WIDTH  operand A, latched on accepted start
B  input  WIDTH  operand B, latched on accepted start
control  input  3  ALU op code, latched on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; result valid
out  output  WIDTH  result, held until next completion
carryout  output  1  carry out of MSB (ADD/SUB), else 0
overflow  output  1  signed overflow (ADD/SUB), else 0
zero  output  1  out == 0
negative  output  1  out[WIDTH-1]

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE; bit counter, carry and shift register clear.
  - busy=0, done=0, out=0, carryout=0, overflow=0, zero=0, negative=0.
  - zero is a registered flag, not derived from out during reset.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on a rising edge with start=1:
  - A, B and control are latched; counter=0.
  - carry register = 1 if control==SUB, else 0.
  - Input changes after acceptance have no effect.
- RUN: each edge processes bit i = counter:
  - ADD: sum = a^b^c; c' = majority(a, b, c).
  - SUB: same as ADD with b inverted.
  - AND/OR/NOR/XOR: bitwise result; carry unchanged.
  - Codes 0 and 1: result bit 0.
  - Result bit shifts into the shift register from the MSB side; counter increments.
- RUN -> DONE on the edge processing bit WIDTH-1. On that same edge:
  - out = completed result.
  - carryout = final carry (ADD/SUB only).
  - overflow = carry-into-MSB XOR carry-out-of-MSB (ADD/SUB only).
  - zero and negative update from the new result.
- DONE: done=1 for exactly one cycle; the next edge goes to IDLE unconditionally.
- Latency: start accepted at edge k -> busy=1 for cycles k+1..k+WIDTH -> done=1 during the cycle after edge k+WIDTH.
- Throughput: one operation per WIDTH+2 cycles.
- out and the flags hold their previous values throughout RUN; they change only on the completing edge.
- start in RUN or DONE is ignored (not queued). A start still held high in the following IDLE cycle is accepted then.
- Reset mid-RUN: the operation is abandoned, no done pulse, all outputs return to reset values.
- busy and done are never high simultaneously.
- carryout and overflow are forced 0 for logic and invalid codes.

Test Plan:
- Reset, then start with ADD, A=5, B=3 -> busy high 32 cycles; done pulses one cycle after edge k+32; out=0x00000008, carryout=0, overflow=0, zero=0.
- SUB, A=3, B=5 -> out=0xFFFFFFFE, negative=1, carryout=0, overflow=0. Then SUB, A=5, B=5 -> out=0, zero=1, carryout=1.
- ADD, A=0x7FFFFFFF, B=1 -> out=0x80000000, overflow=1, negative=1. Then ADD, A=0xFFFFFFFF, B=1 -> out=0, carryout=1, overflow=0.
- NOR, A=0, B=0 -> out=0xFFFFFFFF, carryout=0. XOR, A=0xF0F0F0F0, B=0xFF00FF00 -> out=0x0F F00FF0 i.e. 0x0FF00FF0. Control=1 -> out=0.
- Start ADD 5+3, then pulse start with ADD 1+1 at cycle 10 and change A/B mid-run -> single done, out=0x00000008; the second request is not executed.
- Start ADD, assert reset_n=0 at cycle 15 for one cycle -> outputs immediately 0, busy=0, no done pulse. A subsequent ADD 2+2 completes normally with out=4.
